// File: rtl/core_ctrl.sv
// Sequencer for one weight-load / activation-stream / psum-drain pass of the MAC array.
// Walks the SRAM, L0 and output-FIFO handshakes and reports completion with a done pulse.
module core_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11,
  parameter int nw  = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] w_base,
  input  logic [aw-1:0] x_base,
  input  logic [nw-1:0] n_act,
  input  logic          ofifo_valid,
  output logic          xmem_rd,
  output logic [aw-1:0] xmem_addr,
  output logic          l0_wr,
  output logic          l0_rd,
  output logic [1:0]    inst,
  output logic          ofifo_rd,
  output logic          pmem_wr,
  output logic [nw-1:0] pmem_addr,
  output logic          busy,
  output logic          done
);

  // Phase counter must cover both the flush length and the largest activation count.
  localparam int flw = $clog2(row + col);
  localparam int cw  = ((nw > flw) ? nw : flw) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KWR    = 3'd1,
    KRD    = 3'd2,
    KFLUSH = 3'd3,
    XWR    = 3'd4,
    EXEC   = 3'd5,
    DRAIN  = 3'd6,
    FIN    = 3'd7
  } state_t;

  state_t        state;
  logic [cw-1:0] cnt;
  logic [nw-1:0] n_lat;
  logic [aw-1:0] x_lat;
  logic [nw-1:0] pop_cnt;

  // Pops follow the FIFO's valid directly so no row is lost waiting a cycle.
  assign ofifo_rd = ofifo_valid && ((state == EXEC) || (state == DRAIN)) && (pop_cnt != n_lat);

  // Pass sequencer with registered strobes set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      x_lat     <= '0;
      pop_cnt   <= '0;
      xmem_rd   <= 1'b0;
      xmem_addr <= '0;
      l0_wr     <= 1'b0;
      l0_rd     <= 1'b0;
      inst      <= 2'b00;
      pmem_wr   <= 1'b0;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      l0_wr   <= xmem_rd;
      pmem_wr <= ofifo_rd;
      done    <= 1'b0;
      if (ofifo_rd) pop_cnt <= pop_cnt + nw'(1);
      if (pmem_wr) pmem_addr <= pmem_addr + nw'(1);
      case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x_base;
            n_lat     <= n_act;
            cnt       <= '0;
            pop_cnt   <= '0;
            pmem_addr <= '0;
            busy      <= 1'b1;
            if (n_act == nw'(0)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= KWR;
              xmem_rd   <= 1'b1;
              xmem_addr <= w_base;
            end
          end
        end
        KWR: begin
          if (cnt == cw'(col - 1)) begin
            state   <= KRD;
            xmem_rd <= 1'b0;
            l0_rd   <= 1'b1;
            inst    <= 2'b01;
            cnt     <= '0;
          end else begin
            cnt       <= cnt + cw'(1);
            xmem_addr <= xmem_addr + aw'(1);
          end
        end
        KRD: begin
          if (cnt == cw'(col - 1)) begin
            state <= KFLUSH;
            l0_rd <= 1'b0;
            inst  <= 2'b00;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        KFLUSH: begin
          if (cnt == cw'(row + col - 1)) begin
            state     <= XWR;
            xmem_rd   <= 1'b1;
            xmem_addr <= x_lat;
            cnt       <= '0;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        XWR: begin
          // After the last read, one extra cycle lets its data land in L0.
          if (!xmem_rd) begin
            state <= EXEC;
            l0_rd <= 1'b1;
            inst  <= 2'b10;
            cnt   <= '0;
          end else if (cnt == cw'(n_lat) - cw'(1)) begin
            xmem_rd <= 1'b0;
            cnt     <= cnt + cw'(1);
          end else begin
            cnt       <= cnt + cw'(1);
            xmem_addr <= xmem_addr + aw'(1);
          end
        end
        EXEC: begin
          if (cnt == cw'(n_lat) - cw'(1)) begin
            state <= DRAIN;
            l0_rd <= 1'b0;
            inst  <= 2'b00;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        DRAIN: begin
          if (pmem_wr && (pmem_addr == n_lat - nw'(1))) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          xmem_rd <= 1'b0;
          l0_rd   <= 1'b0;
          inst    <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Checks core_ctrl cycle by cycle against a timeline model of one pass,
// with directed scenarios plus randomized passes, valid patterns, restarts and resets.
module tb_core_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int NW  = 6;

  logic          clk = 1'b0;
  logic          reset, start, ofifo_valid;
  logic [AW-1:0] w_base, x_base;
  logic [NW-1:0] n_act;
  logic          xmem_rd, l0_wr, l0_rd, ofifo_rd, pmem_wr, busy, done;
  logic [AW-1:0] xmem_addr;
  logic [1:0]    inst;
  logic [NW-1:0] pmem_addr;

  core_ctrl #(.row(ROW), .col(COL), .aw(AW), .nw(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .n_act(n_act), .ofifo_valid(ofifo_valid), .xmem_rd(xmem_rd), .xmem_addr(xmem_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .inst(inst), .ofifo_rd(ofifo_rd), .pmem_wr(pmem_wr),
    .pmem_addr(pmem_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // drive values for the next cycle
  logic d_reset = 1'b1, d_start = 1'b0;
  int   d_w = 0, d_x = 0, d_n = 0;
  int   vmode = 0, vcnt = 0;

  // model: a pass is a timeline of cycle indices t = 1.. after the start edge
  bit m_known = 0, m_after_reset = 0, m_active = 0;
  int m_t = 0, m_w = 0, m_x = 0, m_n = 0, m_pops = 0, m_writes = 0, m_fin_t = -1;
  bit m_prev_xrd = 0, m_prev_rd = 0;

  // observed tallies for the hand-computed expectations
  int obs_cyc, obs_xrd, obs_k, obs_e, obs_pw, obs_done, obs_done_t;
  logic [AW-1:0] obs_addrs[$];
  logic [NW-1:0] obs_paddrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (pass cycle %0d)", name, act, exp, m_t);
    end
  endtask

  task automatic step();
    logic e_xrd, e_ord, e_l0rd, e_done, e_busy, e_pwr, e_l0wr;
    logic [1:0] e_inst;
    logic [AW-1:0] e_addr;
    int xs, ex;
    @(negedge clk);
    reset = d_reset;
    start = d_start;
    w_base = AW'(d_w);
    x_base = AW'(d_x);
    n_act = NW'(d_n);
    case (vmode)
      0: ofifo_valid = 1'b1;
      1: ofifo_valid = ((vcnt % 3) == 0);
      default: ofifo_valid = ($urandom_range(0, 2) != 0);
    endcase
    vcnt++;
    #1;
    e_xrd = 0; e_ord = 0; e_l0rd = 0; e_done = 0; e_busy = 0; e_inst = 2'b00; e_addr = '0;
    e_l0wr = m_prev_xrd;
    e_pwr = m_prev_rd;
    if (m_active) begin
      e_busy = 1;
      xs = 3 * COL + ROW + 1;
      ex = xs + m_n + 1;
      if (m_t == m_fin_t) e_done = 1;
      else if (m_n != 0) begin
        if (m_t >= 1 && m_t <= COL) begin e_xrd = 1; e_addr = AW'(m_w + m_t - 1); end
        if (m_t >= xs && m_t < xs + m_n) begin e_xrd = 1; e_addr = AW'(m_x + m_t - xs); end
        if (m_t > COL && m_t <= 2 * COL) begin e_l0rd = 1; e_inst = 2'b01; end
        if (m_t >= ex && m_t < ex + m_n) begin e_l0rd = 1; e_inst = 2'b10; end
        if (m_t >= ex && ofifo_valid && m_pops < m_n) e_ord = 1;
      end
    end
    if (m_known) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("xmem_rd", xmem_rd, e_xrd);
      chk("l0_wr", l0_wr, e_l0wr);
      chk("l0_rd", l0_rd, e_l0rd);
      chk("inst", inst, e_inst);
      chk("ofifo_rd", ofifo_rd, e_ord);
      chk("pmem_wr", pmem_wr, e_pwr);
      if (e_xrd) chk("xmem_addr", xmem_addr, e_addr);
      if (e_pwr) chk("pmem_addr", pmem_addr, m_writes);
      if (m_after_reset) begin
        chk("reset_xmem_addr", xmem_addr, 0);
        chk("reset_pmem_addr", pmem_addr, 0);
      end
    end
    if (xmem_rd === 1'b1) begin obs_xrd++; obs_addrs.push_back(xmem_addr); end
    if (inst === 2'b01) obs_k++;
    if (inst === 2'b10) obs_e++;
    if (pmem_wr === 1'b1) begin obs_pw++; obs_paddrs.push_back(pmem_addr); end
    if (done === 1'b1) begin obs_done++; obs_done_t = obs_cyc; end
    obs_cyc++;
    // advance the model across the coming rising edge
    if (d_reset) begin
      m_known = 1; m_after_reset = 1; m_active = 0; m_prev_xrd = 0; m_prev_rd = 0;
    end else begin
      m_after_reset = 0;
      m_prev_xrd = e_xrd;
      m_prev_rd = e_ord;
      if (e_ord) m_pops++;
      if (e_pwr) begin
        m_writes++;
        if (m_writes == m_n) m_fin_t = m_t + 1;
      end
      if (m_active) begin
        if (e_done) m_active = 0;
        else m_t++;
      end else if (d_start) begin
        m_active = 1; m_t = 1; m_w = d_w; m_x = d_x; m_n = d_n;
        m_pops = 0; m_writes = 0;
        m_fin_t = (d_n == 0) ? 1 : -1;
      end
    end
  endtask

  task automatic run_pass(input int w, input int x, input int n, input int mode,
                          input int rst_at, input int start_at);
    int cnt;
    obs_xrd = 0; obs_k = 0; obs_e = 0; obs_pw = 0; obs_done = 0; obs_done_t = -1;
    obs_addrs.delete(); obs_paddrs.delete();
    d_w = w; d_x = x; d_n = n; vmode = mode; vcnt = 0;
    d_start = 1; obs_cyc = 0;
    step();
    d_start = 0;
    cnt = 0;
    while (m_active && cnt < 3000) begin
      d_start = (start_at > 0 && m_t == start_at);
      d_reset = (rst_at > 0 && m_t == rst_at);
      step();
      cnt++;
    end
    d_start = 0;
    d_reset = 0;
    chk("pass_end_in_budget", (cnt < 3000), 1);
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; n_act = '0;
    d_reset = 1;
    repeat (3) step();
    d_reset = 0;
    step();

    // basic pass with the FIFO always ready
    run_pass('h010, 'h100, 4, 0, 0, 0);
    chk("p1_xrd_count", obs_xrd, 12);
    chk("p1_first_w", obs_addrs[0], 'h010);
    chk("p1_last_w", obs_addrs[7], 'h017);
    chk("p1_first_x", obs_addrs[8], 'h100);
    chk("p1_last_x", obs_addrs[11], 'h103);
    chk("p1_krd_cycles", obs_k, 8);
    chk("p1_exec_cycles", obs_e, 4);
    chk("p1_pmem_wr_count", obs_pw, 4);
    chk("p1_last_paddr", obs_paddrs[3], 3);
    chk("p1_done_count", obs_done, 1);
    chk("p1_done_cycle", obs_done_t, 43);

    // sparse valid: pops only on valid cycles
    run_pass('h020, 'h200, 3, 1, 0, 0);
    chk("p2_pmem_wr_count", obs_pw, 3);
    chk("p2_paddr0", obs_paddrs[0], 0);
    chk("p2_paddr2", obs_paddrs[2], 2);
    chk("p2_done_count", obs_done, 1);

    // reset in the middle of EXEC, then a clean pass
    run_pass('h030, 'h300, 5, 0, 40, 0);
    chk("p3_no_done", obs_done, 0);
    run_pass('h030, 'h300, 5, 0, 0, 0);
    chk("p4_done_cycle", obs_done_t, 45);
    chk("p4_pmem_wr_count", obs_pw, 5);

    // start repeated during the flush is ignored
    run_pass('h040, 'h400, 4, 0, 0, 20);
    chk("p5_done_count", obs_done, 1);
    chk("p5_xrd_count", obs_xrd, 12);
    chk("p5_first_x", obs_addrs[8], 'h400);

    // empty pass
    run_pass('h050, 'h500, 0, 0, 0, 0);
    chk("p6_done_cycle", obs_done_t, 1);
    chk("p6_xrd_count", obs_xrd, 0);
    chk("p6_pmem_wr_count", obs_pw, 0);

    // activation addresses wrap at the top of the SRAM
    run_pass('h060, 'h7FE, 3, 0, 0, 0);
    chk("p7_x0", obs_addrs[8], 'h7FE);
    chk("p7_x1", obs_addrs[9], 'h7FF);
    chk("p7_x2", obs_addrs[10], 'h000);

    for (int p = 0; p < 30; p++) begin
      run_pass($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 63),
               $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0) ? $urandom_range(1, 90) : 0,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
